// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller. Tracks its own tag pipeline of in-flight
// writers (EX plus FWD_STAGES later stages) and drives EX operand selects and the ID stall.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_STAGES = 2,
  parameter int unsigned SEL_W      = $clog2(FWD_STAGES + 1),
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic                          id_wr_en,
  input  logic [REG_ADDR_W-1:0]         id_wr_addr,
  input  logic                          id_is_load,
  input  logic                          flush,
  input  logic                          pipe_hold,
  input  logic                          halt_id,
  input  logic                          halt_ex,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          stall_id,
  output logic [CNT_W-1:0]              stall_cnt
);

  // Tag pipeline: index 0 is EX, index k is the k-th stage after EX.
  logic [FWD_STAGES:0]                 valid_q, valid_d;
  logic [FWD_STAGES:0]                 wr_en_q, wr_en_d;
  logic [FWD_STAGES:0][REG_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  // Load flag only matters in EX (stall) and EX/MEM (forward eligibility).
  logic [1:0]                          is_load_q, is_load_d;
  // Source fields are only consulted for the instruction in EX.
  logic [NUM_SRC*REG_ADDR_W-1:0]       src_addr_q, src_addr_d;
  logic [NUM_SRC-1:0]                  src_used_q, src_used_d;
  logic [CNT_W-1:0]                    cnt_q, cnt_d;
  logic                                load_hit_c;

  // Load-use detection between the ID instruction and a load sitting in EX.
  always_comb begin
    load_hit_c = 1'b0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (id_src_used[j] && (id_src_addr[j*REG_ADDR_W +: REG_ADDR_W] == wr_addr_q[0])) begin
        load_hit_c = 1'b1;
      end
    end
    stall_id = id_valid && !flush && valid_q[0] && wr_en_q[0] && is_load_q[0] && load_hit_c;
  end

  // Forward select search; scanning oldest to youngest lets the youngest producer win.
  always_comb begin
    fwd_sel = '0;
    for (int unsigned j = 0; j < NUM_SRC; j++) begin
      if (!halt_id && !halt_ex && valid_q[0] && src_used_q[j]) begin
        for (int k = int'(FWD_STAGES); k >= 1; k--) begin
          if (valid_q[k] && wr_en_q[k] &&
              (wr_addr_q[k] == src_addr_q[j*REG_ADDR_W +: REG_ADDR_W]) &&
              !((k == 1) && is_load_q[1])) begin
            fwd_sel[j*SEL_W +: SEL_W] = SEL_W'(k);
          end
        end
      end
    end
  end

  // Next-state: counter runs even under pipe_hold; the tag pipeline only advances without it.
  always_comb begin
    valid_d    = valid_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    is_load_d  = is_load_q;
    src_addr_d = src_addr_q;
    src_used_d = src_used_q;
    cnt_d      = cnt_q;
    if (stall_id && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (!pipe_hold) begin
      valid_d    = {valid_q[FWD_STAGES-1:0], (id_valid && !stall_id && !flush)};
      wr_en_d    = {wr_en_q[FWD_STAGES-1:0], id_wr_en};
      wr_addr_d  = {wr_addr_q[FWD_STAGES-1:0], id_wr_addr};
      is_load_d  = {is_load_q[0], id_is_load};
      src_addr_d = id_src_addr;
      src_used_d = id_src_used;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      wr_en_q    <= '0;
      wr_addr_q  <= '0;
      is_load_q  <= '0;
      src_addr_q <= '0;
      src_used_q <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      is_load_q  <= is_load_d;
      src_addr_q <= src_addr_d;
      src_used_q <= src_used_d;
      cnt_q      <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: directed hazard scenarios then random traffic against an
// instruction-history reference model.
module tb_fwd_hazard_ctrl;
  localparam int unsigned AW = 3;
  localparam int unsigned NS = 2;
  localparam int unsigned FS = 2;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 16;

  logic            clk = 1'b0;
  logic            rst, id_valid, id_wr_en, id_is_load, flush, pipe_hold, halt_id, halt_ex;
  logic [NS*AW-1:0] id_src_addr;
  logic [NS-1:0]    id_src_used;
  logic [AW-1:0]    id_wr_addr;
  logic [NS*SW-1:0] fwd_sel, fwd_sel2;
  logic             stall_id, stall_id2;
  logic [CW-1:0]    stall_cnt;
  logic [1:0]       stall_cnt2;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic               v;
    logic               we;
    logic               ld;
    logic [AW-1:0]      wa;
    logic [NS-1:0][AW-1:0] src;
    logic [NS-1:0]      used;
  } ent_t;

  ent_t        hist [FS+1];   // hist[0] = instruction in EX, hist[k] = k stages older
  int unsigned cnt_m, cnt2_m;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.REG_ADDR_W(AW), .NUM_SRC(NS), .FWD_STAGES(FS), .SEL_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .flush(flush), .pipe_hold(pipe_hold), .halt_id(halt_id),
    .halt_ex(halt_ex), .fwd_sel(fwd_sel), .stall_id(stall_id), .stall_cnt(stall_cnt)
  );

  fwd_hazard_ctrl #(.REG_ADDR_W(AW), .NUM_SRC(NS), .FWD_STAGES(FS), .SEL_W(SW), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr),
    .id_is_load(id_is_load), .flush(flush), .pipe_hold(pipe_hold), .halt_id(halt_id),
    .halt_ex(halt_ex), .fwd_sel(fwd_sel2), .stall_id(stall_id2), .stall_cnt(stall_cnt2)
  );

  function automatic bit exp_stall();
    logic [AW-1:0] s;
    if (!id_valid || flush || !hist[0].v || !hist[0].we || !hist[0].ld) return 1'b0;
    for (int j = 0; j < int'(NS); j++) begin
      s = id_src_addr[j*AW +: AW];
      if (id_src_used[j] && (s == hist[0].wa)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int exp_fwd(input int j);
    if (halt_id || halt_ex || !hist[0].v || !hist[0].used[j]) return 0;
    for (int k = 1; k <= int'(FS); k++) begin
      if (hist[k].v && hist[k].we && (hist[k].wa == hist[0].src[j]) && !(k == 1 && hist[k].ld))
        return k;
    end
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic settle_check(input string tag);
    #1;
    chk({tag, ".stall"}, 32'(stall_id), 32'(exp_stall()));
    chk({tag, ".stall_small"}, 32'(stall_id2), 32'(exp_stall()));
    for (int j = 0; j < int'(NS); j++) begin
      chk($sformatf("%s.fwd%0d", tag, j), 32'(fwd_sel[j*SW +: SW]), 32'(exp_fwd(j)));
    end
    chk({tag, ".cnt"}, 32'(stall_cnt), cnt_m);
    chk({tag, ".cnt_small"}, 32'(stall_cnt2), cnt2_m);
  endtask

  // Advance the model with the current inputs, then move to the next drive point.
  task automatic tick();
    bit st;
    st = exp_stall();
    if (rst) begin
      for (int i = 0; i <= int'(FS); i++) hist[i] = '0;
      cnt_m  = 0;
      cnt2_m = 0;
    end else begin
      if (st) begin
        if (cnt_m < 65535) cnt_m++;
        if (cnt2_m < 3) cnt2_m++;
      end
      if (!pipe_hold) begin
        for (int i = int'(FS); i >= 1; i--) hist[i] = hist[i-1];
        hist[0] = '0;
        if (!st && !flush && id_valid) begin
          hist[0].v    = 1'b1;
          hist[0].we   = id_wr_en;
          hist[0].ld   = id_is_load;
          hist[0].wa   = id_wr_addr;
          hist[0].src  = id_src_addr;
          hist[0].used = id_src_used;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic step(input string tag);
    settle_check(tag);
    tick();
  endtask

  task automatic idle();
    rst = 1'b0; id_valid = 1'b0; id_wr_en = 1'b0; id_wr_addr = '0; id_is_load = 1'b0;
    id_src_addr = '0; id_src_used = '0; flush = 1'b0; pipe_hold = 1'b0;
    halt_id = 1'b0; halt_ex = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] wa, input logic ld,
                       input logic [AW-1:0] s0, input logic [AW-1:0] s1, input logic [NS-1:0] used);
    idle();
    id_valid = 1'b1; id_wr_en = we; id_wr_addr = wa; id_is_load = ld;
    id_src_addr = {s1, s0}; id_src_used = used;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= int'(FS); i++) hist[i] = '0;
    cnt_m = 0; cnt2_m = 0;

    idle(); settle_check("reset");
    chk("reset_fwd", 32'(fwd_sel), 32'd0); chk("reset_cnt", 32'(stall_cnt), 32'd0); tick();

    // ALU dependence at distance 1
    issue(1, 3, 0, 0, 0, 2'b00); step("alu_prod");
    issue(0, 0, 0, 3, 0, 2'b01); step("alu_cons");
    idle(); settle_check("alu_d1");
    chk("alu_d1_fwd", 32'(fwd_sel), 32'h1); chk("alu_d1_stall", 32'(stall_id), 32'd0); tick();
    idle(); settle_check("alu_gone"); chk("alu_gone_fwd", 32'(fwd_sel), 32'h0); tick();

    // Two producers: youngest wins
    issue(1, 3, 0, 0, 0, 2'b00); step("two_p1");
    issue(1, 3, 0, 0, 0, 2'b00); step("two_p2");
    issue(0, 0, 0, 3, 0, 2'b01); step("two_c");
    idle(); settle_check("two_young"); chk("two_young_fwd", 32'(fwd_sel), 32'h1); tick();

    // Distance 2 only
    issue(1, 3, 0, 0, 0, 2'b00); step("d2_p");
    issue(0, 3, 0, 0, 0, 2'b00); step("d2_nop");
    issue(0, 0, 0, 3, 0, 2'b01); step("d2_c");
    idle(); settle_check("d2"); chk("d2_fwd", 32'(fwd_sel), 32'h2); tick();

    // Distance 3 is out of forwarding range
    issue(1, 3, 0, 0, 0, 2'b00); step("d3_p");
    issue(0, 3, 0, 0, 0, 2'b00); step("d3_nop1");
    issue(0, 3, 0, 0, 0, 2'b00); step("d3_nop2");
    issue(0, 0, 0, 3, 0, 2'b01); step("d3_c");
    idle(); settle_check("d3"); chk("d3_fwd", 32'(fwd_sel), 32'h0); tick();

    // Load-use on src1: one bubble, then forward from stage 2
    issue(1, 2, 1, 0, 0, 2'b00); step("lu_ld");
    issue(0, 0, 0, 0, 2, 2'b10); settle_check("lu_stall");
    chk("lu_stall_on", 32'(stall_id), 32'd1); tick();
    issue(0, 0, 0, 0, 2, 2'b10); settle_check("lu_release");
    chk("lu_stall_off", 32'(stall_id), 32'd0); chk("lu_cnt", 32'(stall_cnt), 32'd1); tick();
    idle(); settle_check("lu_fwd");
    chk("lu_fwd_sel", 32'(fwd_sel), 32'h8); chk("lu_cnt_after", 32'(stall_cnt), 32'd1); tick();

    // Flush beats a load-use match
    issue(1, 5, 1, 0, 0, 2'b00); step("fl_ld");
    issue(0, 0, 0, 5, 0, 2'b01); flush = 1'b1; settle_check("fl_both");
    chk("fl_stall", 32'(stall_id), 32'd0); tick();
    idle(); settle_check("fl_after");
    chk("fl_bubble_fwd", 32'(fwd_sel), 32'h0); chk("fl_cnt", 32'(stall_cnt), 32'd1); tick();

    // pipe_hold freezes forwarding; halt_ex forces zero
    issue(1, 4, 0, 0, 0, 2'b00); step("ph_p");
    issue(0, 0, 0, 4, 0, 2'b01); step("ph_c");
    for (int i = 0; i < 3; i++) begin
      idle(); pipe_hold = 1'b1; settle_check("ph_hold");
      chk($sformatf("ph_hold_fwd%0d", i), 32'(fwd_sel), 32'h1); tick();
    end
    idle(); pipe_hold = 1'b1; halt_ex = 1'b1; settle_check("ph_halt");
    chk("ph_halt_fwd", 32'(fwd_sel), 32'h0); tick();
    idle(); settle_check("ph_release"); chk("ph_release_fwd", 32'(fwd_sel), 32'h1); tick();

    // Reset during a stall
    issue(1, 1, 1, 0, 0, 2'b00); step("rs_ld");
    issue(0, 0, 0, 1, 0, 2'b01); rst = 1'b1; settle_check("rs_stall");
    chk("rs_stall_on", 32'(stall_id), 32'd1); tick();
    issue(0, 0, 0, 1, 0, 2'b01); settle_check("rs_after");
    chk("rs_stall_off", 32'(stall_id), 32'd0); chk("rs_fwd", 32'(fwd_sel), 32'h0);
    chk("rs_cnt", 32'(stall_cnt), 32'd0); tick();

    // Five stall cycles under pipe_hold saturate the 2-bit counter
    issue(1, 6, 1, 0, 0, 2'b00); step("sat_ld");
    for (int i = 0; i < 5; i++) begin
      issue(0, 0, 0, 6, 0, 2'b01); pipe_hold = 1'b1; settle_check("sat_stall");
      chk($sformatf("sat_stall_on%0d", i), 32'(stall_id), 32'd1); tick();
    end
    idle(); pipe_hold = 1'b1; settle_check("sat_done");
    chk("sat_small", 32'(stall_cnt2), 32'd3); chk("sat_big", 32'(stall_cnt), 32'd5); tick();
    idle(); step("sat_release");

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst         = ($urandom_range(0, 63) == 0);
      id_valid    = ($urandom_range(0, 7) != 0);
      id_wr_en    = ($urandom_range(0, 3) != 0);
      id_wr_addr  = AW'($urandom);
      id_is_load  = ($urandom_range(0, 2) == 0);
      id_src_addr = (NS*AW)'($urandom);
      id_src_used = NS'($urandom);
      flush       = ($urandom_range(0, 9) == 0);
      pipe_hold   = ($urandom_range(0, 5) == 0);
      halt_id     = ($urandom_range(0, 19) == 0);
      halt_ex     = ($urandom_range(0, 19) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and load-use hazard controller for the pipeline.
- Instead of taking per-stage destination info from the pipeline registers, it tracks its own tag pipeline of in-flight writers: ID/EX slot plus FWD_STAGES later stages.
- Each cycle it produces per-operand forward selects for the instruction in EX, a load-use stall for ID, and a saturating stall-cycle counter.
- Sits beside the decode/execute boundary and drives the EX operand muxes and the IF/ID hold.

Parameters:
- REG_ADDR_W, 3, register address width.
- NUM_SRC, 2, source operands per instruction.
- FWD_STAGES, 2, forwardable stages after EX; stage 1 = EX/MEM, stage 2 = MEM/WB, ...
- SEL_W, $clog2(FWD_STAGES+1), forward-select width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_src_addr  in  NUM_SRC*REG_ADDR_W  ID source addresses; operand j at bits [j*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  in  NUM_SRC  per-operand read enable.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_addr  in  REG_ADDR_W  ID destination.
- id_is_load  in  1  ID instruction is a load.
- flush  in  1  branch taken in EX; squash the ID instruction.
- pipe_hold  in  1  global pipeline freeze (memory stall).
- halt_id  in  1  halt in ID.
- halt_ex  in  1  halt in EX.
- fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = regfile value, k = result from stage k.
- stall_id  out  1  hold IF/ID and insert a bubble into EX.
- stall_cnt  out  CNT_W  saturating count of stall_id cycles.

Behaviour:
- Tag entry fields: valid, wr_en, wr_addr, is_load, src_addr[NUM_SRC], src_used. T[0] = instruction in EX; T[1..FWD_STAGES] = later stages.
- Reset, synchronous: every T[i].valid = 0 and stall_cnt = 0. Consequently fwd_sel = 0 and stall_id = 0 in the cycle after rst is sampled high. rst has priority over pipe_hold and flush. Reset mid-stall clears the stall immediately.
- stall_id, combinational: asserted when all of the following hold:
  - id_valid, !flush, T[0].valid, T[0].wr_en, T[0].is_load;
  - some operand j with id_src_used[j] and id_src_addr[j] == T[0].wr_addr.
  - Asserted even while pipe_hold = 1.
- Shift on each clk edge when !pipe_hold && !rst:
  - T[i] <= T[i-1] for i >= 1.
  - T[0] <= bubble (valid = 0) if stall_id || flush || !id_valid; otherwise T[0] <= the ID fields.
  - T[FWD_STAGES] is discarded.
- pipe_hold = 1: all T hold their values; stall_cnt still increments if stall_id.
- fwd_sel[j], combinational:
  - Forced to 0 if halt_id || halt_ex || !T[0].valid || !T[0].src_used[j].
  - Otherwise, the smallest k in 1..FWD_STAGES with T[k].valid, T[k].wr_en, and T[k].wr_addr == T[0].src_addr[j]. The youngest producer wins.
  - A match with k == 1 and T[1].is_load is not eligible; the search continues to older stages, and falls back to 0 if none.
  - No match gives 0.
- Load-use latency: exactly one bubble. After the stall, the load is in T[2] and the dependent in T[0], giving fwd_sel = 2 (with FWD_STAGES >= 2).
- stall_cnt increments by 1 per cycle with stall_id = 1 and saturates at all-ones. No wrap-around.
- Simultaneous flush and load-use match: flush wins. stall_id = 0 and a bubble enters T[0].
- Width rules: address compares are full REG_ADDR_W equality. No register is hardwired to zero.

Test Plan:
- ALU dependence, distance 1:
  - Stimulus: ADD r3 issues, next instruction reads r3 on src0.
  - Required: fwd_sel[src0] = 1 for one cycle, stall_id = 0.
- Two producers of r3:
  - Stimulus: r3 written at distance 1 and distance 2.
  - Required: fwd_sel = 1 (youngest wins); distance-2 only gives fwd_sel = 2; distance 3 gives 0.
- Load-use:
  - Stimulus: LD r2, then ADD reading r2 on src1.
  - Required: stall_id = 1 for exactly 1 cycle; T[0] bubble; then fwd_sel[src1] = 2; stall_cnt = 1.
- Flush and stall together:
  - Stimulus: flush = 1 in the same cycle a load-use match exists.
  - Required: stall_id = 0, bubble in T[0], stall_cnt unchanged.
- pipe_hold and halt:
  - Stimulus: pipe_hold = 1 for 3 cycles during a distance-1 dependence.
  - Required: fwd_sel stays 1 for all 3 cycles. Asserting halt_ex forces fwd_sel = 0.
- Reset and saturation:
  - Stimulus: rst during stall_id = 1.
  - Required: next cycle stall_id = 0, fwd_sel = 0, stall_cnt = 0.
  - Stimulus: with CNT_W = 2, 5 consecutive stall cycles.
  - Required: stall_cnt = 3.
